// File: rtl/fetch_sched_pkg.sv
// Purpose: shared FSM state type, RRESP codes and sizing helper for the fetch burst scheduler.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package fetch_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Width of a counter that must hold 0..max_outst inclusive.
   function automatic int outst_w(input int max_outst);
      return $clog2(max_outst + 1);
   endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Purpose: row address accumulator; load latches base and stride, advance adds stride (wraps mod 2^ADDR_W).
// Latency: addr_o reflects a load or advance one cycle after the strobe.
// Backpressure: none; advance_i is only pulsed on an accepted command, so addr_o is stable while a command waits.
// Ports: clk/rst_n clock and async active-low reset; load_i, base_i, stride_i start a new scan;
//        advance_i steps to the next row; addr_o current row start address.
module fetch_addr_gen
   import fetch_sched_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W-1:0] stride_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;

   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      if (load_i) begin
         addr_d   = base_i;
         stride_d = stride_i;
      end else if (advance_i) begin
         addr_d = addr_q + stride_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         stride_q <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
      end
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/fetch_burst_scheduler.sv
// Purpose: turns a table scan (base, stride, rows, beats) into one AXI read burst command per row.
// Latency: first command valid the cycle after start; done pulses two cycles after the last completion.
// Backpressure: cmd_valid/addr/len hold until cmd_ready; at most MAX_OUTST bursts are in flight.
// Ports: ACLK/ARESETN clock and async active-low reset; cfg_* scan configuration sampled on cfg_start;
//        cmd_* burst command handshake; cpl_* burst completions; busy/done/error/rows_done status.
module fetch_burst_scheduler
   import fetch_sched_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int ROWS_W    = 16,
   parameter int MAX_OUTST = 4
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              cfg_start,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_row_stride,
   input  logic [ROWS_W-1:0] cfg_row_count,
   input  logic [8:0]        cfg_beats,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [7:0]        cmd_len,
   input  logic              cpl_valid,
   input  logic [1:0]        cpl_resp,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ROWS_W-1:0] rows_done
);

   localparam int               OUT_W = outst_w(MAX_OUTST);
   localparam logic [OUT_W-1:0] MAX_O = OUT_W'(MAX_OUTST);

   state_e            state_q, state_d;
   logic [ROWS_W-1:0] rows_q, rows_d;
   logic [ROWS_W-1:0] issued_q, issued_d;
   // Completed-burst count; it is the same quantity reported on rows_done.
   logic [ROWS_W-1:0] cpl_cnt_q, cpl_cnt_d;
   logic [OUT_W-1:0]  outst_q, outst_d;
   logic [7:0]        len_q, len_d;
   logic              err_q, err_d;
   logic              pend_q, pend_d;
   logic              done_q, done_d;

   logic start_acc, beats_bad, can_issue, hs, cpl_ok, cpl_err;

   assign start_acc = (state_q == IDLE) && cfg_start;
   assign beats_bad = (cfg_beats == 9'd0) || (cfg_beats > 9'd256);
   assign can_issue = (issued_q < rows_q) && (outst_q < MAX_O) && !err_q;
   // pend_q keeps an already-offered command alive even if error rises before it is accepted.
   assign cmd_valid = (state_q == ISSUE) && (pend_q || can_issue);
   assign hs        = cmd_valid && cmd_ready;
   // Completions only matter during a scan; with nothing outstanding they are spurious.
   assign cpl_ok    = (state_q != IDLE) && cpl_valid && (outst_q != '0);
   assign cpl_err   = (state_q != IDLE) && cpl_valid && ((outst_q == '0) || (cpl_resp != OKAY));

   always_comb begin
      state_d   = state_q;
      rows_d    = rows_q;
      issued_d  = issued_q;
      cpl_cnt_d = cpl_cnt_q;
      outst_d   = outst_q;
      len_d     = len_q;
      err_d     = err_q;
      pend_d    = cmd_valid && !cmd_ready;
      done_d    = (state_q == FIN);

      if (start_acc) begin
         rows_d    = cfg_row_count;
         len_d     = 8'(cfg_beats - 9'd1);
         issued_d  = '0;
         cpl_cnt_d = '0;
         outst_d   = '0;
         err_d     = beats_bad;
      end else begin
         if (hs) begin
            issued_d = issued_q + ROWS_W'(1);
         end
         if (cpl_ok) begin
            cpl_cnt_d = cpl_cnt_q + ROWS_W'(1);
         end
         if (hs && !cpl_ok) begin
            outst_d = outst_q + OUT_W'(1);
         end else if (!hs && cpl_ok) begin
            outst_d = outst_q - OUT_W'(1);
         end
         if (cpl_err) begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = (beats_bad || (cfg_row_count == '0)) ? FIN : ISSUE;
            end
         end
         ISSUE: begin
            if ((issued_q == rows_q) || (err_q && !pend_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (outst_q == '0) begin
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         rows_q    <= '0;
         issued_q  <= '0;
         cpl_cnt_q <= '0;
         outst_q   <= '0;
         len_q     <= '0;
         err_q     <= 1'b0;
         pend_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rows_q    <= rows_d;
         issued_q  <= issued_d;
         cpl_cnt_q <= cpl_cnt_d;
         outst_q   <= outst_d;
         len_q     <= len_d;
         err_q     <= err_d;
         pend_q    <= pend_d;
         done_q    <= done_d;
      end
   end

   fetch_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk      (ACLK),
      .rst_n    (ARESETN),
      .load_i   (start_acc),
      .advance_i(hs),
      .base_i   (cfg_base_addr),
      .stride_i (cfg_row_stride),
      .addr_o   (cmd_addr)
   );

   // busy covers ISSUE, DRAIN and FIN; done is raised on the following (IDLE) cycle.
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign error     = err_q;
   assign rows_done = cpl_cnt_q;
   assign cmd_len   = len_q;

endmodule

// File: tb/tb_fetch_burst_scheduler.sv
// Purpose: self-checking bench for fetch_burst_scheduler with a scan-level reference model.
// Latency: n/a.
// Backpressure: drives cmd_ready stalls and withheld completions.
module tb_fetch_burst_scheduler;
   localparam int AW = 32;
   localparam int RW = 16;
   localparam int MO = 4;
   localparam logic [1:0] R_OKAY   = 2'b00;
   localparam logic [1:0] R_SLVERR = 2'b10;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b1;
   logic          cfg_start = 1'b0;
   logic [AW-1:0] cfg_base_addr = '0;
   logic [AW-1:0] cfg_row_stride = '0;
   logic [RW-1:0] cfg_row_count = '0;
   logic [8:0]    cfg_beats = '0;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic          cpl_valid = 1'b0;
   logic [1:0]    cpl_resp = 2'b00;
   logic          busy;
   logic          done;
   logic          error;
   logic [RW-1:0] rows_done;

   always #5 ACLK = ~ACLK;

   fetch_burst_scheduler #(.ADDR_W(AW), .ROWS_W(RW), .MAX_OUTST(MO)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_start(cfg_start),
      .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride),
      .cfg_row_count(cfg_row_count), .cfg_beats(cfg_beats),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cpl_valid(cpl_valid), .cpl_resp(cpl_resp),
      .busy(busy), .done(done), .error(error), .rows_done(rows_done)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model (scan-level view) ----------------
   bit            m_active = 0;
   bit            m_err = 0;
   bit            prev_pend = 0;
   int            m_issued = 0;
   int            m_rows = 0;
   int            m_outst = 0;
   int            m_rd = 0;
   logic [AW-1:0] m_base = '0;
   logic [AW-1:0] m_stride = '0;
   logic [7:0]    m_len = '0;
   bit            ev, mh, mc;
   logic [AW-1:0] ea;

   always @(negedge ACLK) begin
      if (!ARESETN) begin
         chk("rst_outputs", {cmd_valid, busy, done, error, rows_done, cmd_addr, cmd_len}, 64'd0);
         m_active = 0; m_err = 0; prev_pend = 0; m_issued = 0; m_outst = 0; m_rd = 0;
      end else begin
         ev = m_active && (prev_pend || (m_issued < m_rows && m_outst < MO && !m_err));
         chk("cmd_valid", cmd_valid, ev);
         if (cmd_valid && m_active) begin
            ea = m_base + m_stride * AW'(m_issued);
            chk("cmd_addr", cmd_addr, ea);
            chk("cmd_len", cmd_len, m_len);
         end
         chk("rows_done", rows_done, m_rd);
         chk("error", error, m_err);
         if (done) begin
            chk("done_legal", m_active && m_outst == 0 && (m_issued == m_rows || m_err), 1);
            chk("busy_at_done", busy, 0);
            m_active = 0;
         end else begin
            chk("busy", busy, m_active);
         end
         // events sampled at the coming rising edge
         mh = cmd_valid && cmd_ready;
         prev_pend = cmd_valid && !cmd_ready;
         if (!m_active && cfg_start) begin
            m_active = 1;
            m_base = cfg_base_addr; m_stride = cfg_row_stride;
            m_rows = int'(cfg_row_count);
            m_len = 8'((int'(cfg_beats) - 1) & 255);
            m_err = (cfg_beats < 1) || (cfg_beats > 256);
            m_issued = 0; m_outst = 0; m_rd = 0;
         end else if (m_active) begin
            mc = 0;
            if (cpl_valid) begin
               if (m_outst == 0) m_err = 1;
               else begin
                  mc = 1; m_rd++;
                  if (cpl_resp != R_OKAY) m_err = 1;
               end
            end
            if (mh) m_issued++;
            m_outst = m_outst + int'(mh) - int'(mc);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   int            cyc = 0;
   int            hs_count = 0;
   int            done_cnt = 0;
   bit            auto_cpl = 0;
   int            auto_n = 0;
   int            auto_err_idx = 0;
   int            due_q[$];
   logic [AW-1:0] hs_addr[$];
   logic [7:0]    hs_len[$];

   function automatic logic [AW-1:0] addr_at(input int i);
      if (i < hs_addr.size()) return hs_addr[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [7:0] len_at(input int i);
      if (i < hs_len.size()) return hs_len[i];
      return 8'hEE;
   endfunction

   task automatic tick();
      if (cmd_valid && cmd_ready) begin
         hs_count++;
         hs_addr.push_back(cmd_addr);
         hs_len.push_back(cmd_len);
         if (auto_cpl) due_q.push_back(cyc + 5);
      end
      @(posedge ACLK);
      #1;
      cyc++;
      if (done) done_cnt++;
      if (auto_cpl) begin
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            void'(due_q.pop_front());
            auto_n++;
            cpl_valid = 1'b1;
            cpl_resp  = (auto_n == auto_err_idx) ? R_SLVERR : R_OKAY;
         end else begin
            cpl_valid = 1'b0;
            cpl_resp  = R_OKAY;
         end
      end
   endtask

   task automatic clear_log();
      hs_count = 0; done_cnt = 0; auto_n = 0;
      hs_addr.delete(); hs_len.delete(); due_q.delete();
   endtask

   task automatic start_scan(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int rows, input int beats);
      clear_log();
      cfg_base_addr = b; cfg_row_stride = s;
      cfg_row_count = RW'(rows); cfg_beats = 9'(beats);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic cpl_pulse(input logic [1:0] r);
      cpl_valid = 1'b1; cpl_resp = r;
      tick();
      cpl_valid = 1'b0; cpl_resp = R_OKAY;
   endtask

   task automatic wait_done(input string name, input int max_cyc);
      int base_cnt;
      int n;
      base_cnt = done_cnt;
      n = 0;
      while (done_cnt == base_cnt && n < max_cyc) begin
         tick();
         n++;
      end
      chk(name, done_cnt != base_cnt, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      #1 ARESETN = 1'b0;
      repeat (3) tick();
      chk("reset_cmd_valid", cmd_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rows_done", rows_done, 0);
      ARESETN = 1'b1;
      tick();

      // Basic three-row scan, completions 5 cycles after each issue.
      cmd_ready = 1'b1; auto_cpl = 1; auto_err_idx = 0;
      start_scan(32'h1000, 32'h40, 3, 8);
      wait_done("t1_done", 80);
      repeat (3) tick();
      chk("t1_hs_count", hs_count, 3);
      chk("t1_addr0", addr_at(0), 32'h1000);
      chk("t1_addr1", addr_at(1), 32'h1040);
      chk("t1_addr2", addr_at(2), 32'h1080);
      chk("t1_len", len_at(2), 8'd7);
      chk("t1_rows_done", rows_done, 3);
      chk("t1_error", error, 0);
      chk("t1_single_done", done_cnt, 1);

      // Outstanding limit with withheld completions.
      auto_cpl = 0;
      start_scan(32'h2000, 32'h100, 10, 4);
      repeat (15) tick();
      chk("t2_cap_hs", hs_count, 4);
      chk("t2_cap_valid", cmd_valid, 0);
      for (int k = 0; k < 6; k++) begin
         cpl_pulse(R_OKAY);
         repeat (3) tick();
         chk("t2_one_more", hs_count, 5 + k);
      end
      for (int k = 0; k < 4; k++) cpl_pulse(R_OKAY);
      wait_done("t2_done", 20);
      chk("t2_rows_done", rows_done, 10);
      chk("t2_addr9", addr_at(9), 32'h2900);

      // Stall row 1 for 6 cycles; a start during the scan must be ignored.
      auto_cpl = 1; cmd_ready = 1'b1;
      start_scan(32'h3000, 32'h80, 3, 16);
      for (int n = 0; n < 10 && hs_count < 1; n++) tick();
      cmd_ready = 1'b0;
      cfg_base_addr = 32'hDEAD_0000; cfg_start = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         cfg_start = 1'b0;
         chk("t3_stall_valid", cmd_valid, 1);
         chk("t3_stall_addr", cmd_addr, 32'h3080);
         chk("t3_stall_issued", hs_count, 1);
      end
      cmd_ready = 1'b1;
      wait_done("t3_done", 80);
      chk("t3_hs_count", hs_count, 3);
      chk("t3_len", len_at(1), 8'd15);
      chk("t3_addr2", addr_at(2), 32'h3100);

      // SLVERR on the 2nd completion stops further issue.
      auto_err_idx = 2;
      start_scan(32'h4000, 32'h20, 8, 2);
      wait_done("t4_done", 100);
      chk("t4_error", error, 1);
      chk("t4_hs_count", hs_count, 5);
      chk("t4_rows_done", rows_done, 5);
      auto_err_idx = 0;
      start_scan(32'h5000, 32'h10, 1, 1);
      chk("t4_error_cleared", error, 0);
      wait_done("t4b_done", 40);
      chk("t4b_len", len_at(0), 8'd0);

      // rows=0 and illegal beat counts finish without commands.
      start_scan(32'h0, 32'h0, 0, 4);
      chk("t5_fin_busy", busy, 1);
      chk("t5_fin_nodone", done, 0);
      tick();
      chk("t5_done_at_2", done, 1);
      tick();
      chk("t5_done_once", done, 0);
      for (int k = 0; k < 2; k++) begin
         start_scan(32'h100, 32'h10, 4, (k == 0) ? 0 : 257);
         chk("t5_bad_beats_err", error, 1);
         tick();
         chk("t5_bad_beats_done", done, 1);
         chk("t5_bad_beats_nocmd", hs_count, 0);
      end

      // Address wrap-around with maximum burst length.
      start_scan(32'hFFFF_FFC0, 32'h40, 2, 256);
      wait_done("t6_done", 60);
      chk("t6_addr0", addr_at(0), 32'hFFFF_FFC0);
      chk("t6_addr1", addr_at(1), 32'h0000_0000);
      chk("t6_len", len_at(1), 8'hFF);

      // Reset mid-scan, then a stray completion in IDLE, then a fresh scan.
      auto_cpl = 0;
      start_scan(32'h6000, 32'h40, 6, 4);
      repeat (3) tick();
      #2 ARESETN = 1'b0;
      #1;
      chk("t7_async_busy", busy, 0);
      chk("t7_async_rows_done", rows_done, 0);
      chk("t7_async_addr", cmd_addr, 0);
      chk("t7_async_valid", cmd_valid, 0);
      clear_log();
      repeat (2) tick();
      ARESETN = 1'b1;
      tick();
      cpl_pulse(R_SLVERR);
      tick();
      chk("t7_idle_cpl_rows", rows_done, 0);
      chk("t7_idle_cpl_err", error, 0);
      auto_cpl = 1;
      start_scan(32'h7000, 32'h40, 2, 4);
      wait_done("t7_done", 60);
      chk("t7_rows_done", rows_done, 2);
      chk("t7_addr1", addr_at(1), 32'h7040);

      repeat (2) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
